store_buffer: RTL

//  Downstream neighbour of the memory unit: accepts store requests (write, write_address, DATA_wb, size),

---
 rtl/store_buffer_if.sv | 48 ++++
 rtl/store_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: store-request side from the memory unit and the
// data-memory write port. The slave modport is the store buffer itself.
// Optional store-to-load forwarding signals exist only when SB_FWD_EN is defined.
interface store_buffer_if;
    // store request side
    logic        write;
    logic [31:0] write_address;
    logic [31:0] DATA_wb;
    logic [1:0]  size;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        misalign;
    // memory write port
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
`ifdef SB_FWD_EN
    // load forwarding probe
    logic [31:0] load_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    modport slave (
        input  write, write_address, DATA_wb, size, mem_ack, load_addr,
        output full, empty, overflow, misalign,
        output mem_req, mem_addr, mem_wdata, mem_be, fwd_hit, fwd_data
    );
    modport master (
        output write, write_address, DATA_wb, size, mem_ack, load_addr,
        input  full, empty, overflow, misalign,
        input  mem_req, mem_addr, mem_wdata, mem_be, fwd_hit, fwd_data
    );
`else
    modport slave (
        input  write, write_address, DATA_wb, size, mem_ack,
        output full, empty, overflow, misalign,
        output mem_req, mem_addr, mem_wdata, mem_be
    );
    modport master (
        output write, write_address, DATA_wb, size, mem_ack,
        input  full, empty, overflow, misalign,
        input  mem_req, mem_addr, mem_wdata, mem_be
    );
`endif
endinterface

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry in-order store FIFO between the memory unit and
// the data memory. Byte/half/word stores are encoded at enqueue into a word
// address, lane-replicated data and byte enables, then drained one per
// req/ack handshake. Misaligned half/word stores are discarded.
// Optional feature macro: SB_FWD_EN (full-word store-to-load forwarding).
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    store_buffer_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t       state;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic [29:0] ent_addr [DEPTH];
    logic [31:0] ent_data [DEPTH];
    logic [3:0]  ent_be   [DEPTH];

    logic        req_valid;
    logic        aligned;
    logic [3:0]  enc_be;
    logic [31:0] enc_data;
    logic        pop;
    logic        push;
    logic        drop;
    logic [PW-1:0] nxt_ptr;

    // Status flags are pure decodes of the occupancy count
    assign bus.full  = (count == (PW+1)'(DEPTH));
    assign bus.empty = (count == '0);

    // Encode the incoming store and decide push/pop/drop for this cycle
    always_comb begin
        req_valid = (bus.write === 1'b1) && (bus.size != 2'b00);
        aligned   = 1'b1;
        enc_be    = 4'b1111;
        enc_data  = bus.DATA_wb;
        case (bus.size)
            2'b01: begin
                enc_be   = 4'b0001 << bus.write_address[1:0];
                enc_data = {4{bus.DATA_wb[7:0]}};
            end
            2'b10: begin
                aligned  = ~bus.write_address[0];
                enc_be   = 4'b0011 << bus.write_address[1:0];
                enc_data = {2{bus.DATA_wb[15:0]}};
            end
            default: begin
                aligned  = (bus.write_address[1:0] == 2'b00);
                enc_be   = 4'b1111;
                enc_data = bus.DATA_wb;
            end
        endcase
        pop     = (state == REQ) && bus.mem_req && bus.mem_ack;
        push    = req_valid && aligned && (!bus.full || pop);
        drop    = req_valid && aligned && bus.full && !pop;
        nxt_ptr = rd_ptr + PW'(1);
    end

    // Entry storage; contents are only meaningful while counted, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= bus.write_address[31:2];
            ent_data[wr_ptr] <= enc_data;
            ent_be[wr_ptr]   <= enc_be;
        end
    end

    // Pointers, occupancy and sticky/pulse status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
            bus.misalign <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
            if (drop) bus.overflow <= 1'b1;
            bus.misalign <= req_valid && !aligned;
        end
    end

    // Drain FSM: presents the head entry and holds it until acknowledged.
    // The head stays counted while on the port, so back-to-back loads read rd_ptr+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        bus.mem_addr  <= {ent_addr[rd_ptr], 2'b00};
                        bus.mem_wdata <= ent_data[rd_ptr];
                        bus.mem_be    <= ent_be[rd_ptr];
                        bus.mem_req   <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (pop) begin
                        if (count > (PW+1)'(1)) begin
                            bus.mem_addr  <= {ent_addr[nxt_ptr], 2'b00};
                            bus.mem_wdata <= ent_data[nxt_ptr];
                            bus.mem_be    <= ent_be[nxt_ptr];
                        end else begin
                            bus.mem_req <= 1'b0;
                            bus.mem_be  <= '0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SB_FWD_EN
    logic [PW-1:0] fwd_idx;
    logic [1:0]    unused_load_lsb;

    assign unused_load_lsb = bus.load_addr[1:0];

    // Oldest-to-youngest scan so the youngest matching entry wins
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        fwd_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (ent_addr[fwd_idx] == bus.load_addr[31:2])) begin
                bus.fwd_hit  = (ent_be[fwd_idx] == 4'b1111);
                bus.fwd_data = ent_data[fwd_idx];
            end
        end
    end
`endif

endmodule
